// File: rtl/srl_fifo_pkg.sv
// srl_fifo_pkg: shared types and helpers for the SRL-backed FIFO.
//   state_t     : controller state (EMPTY / ONE / MANY)
//   level_width : bit width needed to express occupancy 0..DEPTH+1
package srl_fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    MANY  = 2'd2
  } state_t;

  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/srl_fifo_ctrl_if.sv
// srl_fifo_ctrl_if: valid/ready stream bundle around the FIFO.
//   in_data/in_valid/in_ready    : producer side
//   out_data/out_valid/out_ready : consumer side
//   level                        : total occupancy, 0..DEPTH+1
//   master : the environment (producer + consumer)
//   slave  : the FIFO
interface srl_fifo_ctrl_if
  import srl_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned LW = level_width(DEPTH);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [LW-1:0]    level;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, level
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, level
  );
endinterface

// File: rtl/srl_fifo_store.sv
// srl_fifo_store: per-bit shift register with a variable read tap.
//   clk : rising-edge clock
//   ce  : shift enable; d enters at tap 0, older words move up
//   d   : word shifted in
//   a   : tap address (0 = newest)
//   q   : word at tap a (combinational)
// No reset and a single enable so each bit maps onto an SRL cell.
module srl_fifo_store
  import srl_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  input  logic [AW-1:0]    a,
  output logic [WIDTH-1:0] q
);

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk) begin
      if (ce) sr <= {sr[DEPTH-2:0], d[b]};
    end

    assign q[b] = sr[a];
  end

endmodule

// File: rtl/srl_fifo_ctrl.sv
// srl_fifo_ctrl: valid/ready FIFO of DEPTH+1 entries built from an SRL
// store (DEPTH words) plus a registered head word.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : srl_fifo_ctrl_if slave (in_*, out_*, level)
// in_ready and level are decodes of registers only; out_data is a register.
module srl_fifo_ctrl
  import srl_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  srl_fifo_ctrl_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = level_width(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  state_t           state, state_nx;
  logic [AW:0]      srl_cnt, srl_cnt_nx;
  logic [AW:0]      cnt_m1;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tap_q;
  logic             out_valid;
  logic             in_ready;
  logic             push, pop;
  logic             shift_en;
  logic             load_bypass;
  logic             load_tap;

  assign out_valid = (state != EMPTY);
  assign in_ready  = (srl_cnt != CNT_FULL);
  assign push      = bus.in_valid & in_ready;
  assign pop       = out_valid & bus.out_ready;
  assign cnt_m1    = srl_cnt - CNT_ONE;

  srl_fifo_store #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_store (
    .clk (clk),
    .ce  (shift_en),
    .d   (bus.in_data),
    .a   (cnt_m1[AW-1:0]),
    .q   (tap_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      srl_cnt <= '0;
      head_q  <= '0;
    end else begin
      state   <= state_nx;
      srl_cnt <= srl_cnt_nx;
      if (load_bypass)   head_q <= bus.in_data;
      else if (load_tap) head_q <= tap_q;
    end
  end

  always_comb begin
    state_nx    = state;
    srl_cnt_nx  = srl_cnt;
    shift_en    = 1'b0;
    load_bypass = 1'b0;
    load_tap    = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          load_bypass = 1'b1;
          state_nx    = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_bypass = 1'b1;
        end else if (push) begin
          shift_en   = 1'b1;
          srl_cnt_nx = CNT_ONE;
          state_nx   = MANY;
        end else if (pop) begin
          state_nx = EMPTY;
        end
      end
      MANY: begin
        // Head reload reads the oldest tap before this edge's shift moves it.
        load_tap = pop;
        shift_en = push;
        if (push && !pop) begin
          srl_cnt_nx = srl_cnt + CNT_ONE;
        end else if (pop && !push) begin
          srl_cnt_nx = cnt_m1;
          if (srl_cnt == CNT_ONE) state_nx = ONE;
        end
      end
      default: begin
        state_nx   = EMPTY;
        srl_cnt_nx = '0;
      end
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = head_q;
  assign bus.level     = LW'(srl_cnt) + LW'(out_valid);

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
module tb_srl_fifo_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CAP   = DEPTH + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  srl_fifo_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  srl_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] mq[$];

  typedef struct {
    bit         iv;
    logic [7:0] d;
    bit         ordy;
    bit         e_ov;
    logic [7:0] e_od;
    bit         e_ir;
    int         e_lvl;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit iv, input logic [7:0] d, input bit ordy);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  // Compare all outputs against the queue model.
  task automatic chk_model(input string tag);
    chk({tag, ".out_valid"}, int'(bus.out_valid), int'(mq.size() != 0));
    if (mq.size() != 0) chk({tag, ".out_data"}, int'(bus.out_data), int'(mq[0]));
    chk({tag, ".in_ready"}, int'(bus.in_ready), int'(mq.size() != CAP));
    chk({tag, ".level"}, int'(bus.level), int'(mq.size()));
  endtask

  // One clock with the given inputs; the model decides accept/pop from its own occupancy.
  task automatic mstep(input bit iv, input logic [7:0] d, input bit ordy, input string tag);
    bit push_m, pop_m;
    push_m = iv && (mq.size() != CAP);
    pop_m  = ordy && (mq.size() != 0);
    drive(iv, d, ordy);
    @(posedge clk); #1;
    if (pop_m) void'(mq.pop_front());
    if (push_m) mq.push_back(d);
    chk_model(tag);
  endtask

  task automatic drain_all();
    for (int i = 0; i < 40 && mq.size() != 0; i++) mstep(1'b0, 8'h00, 1'b1, "drain");
    chk("drain.empty", int'(bus.level), 0);
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", int'(bus.out_valid), 0);
    chk("reset.out_data",  int'(bus.out_data), 0);
    chk("reset.in_ready",  int'(bus.in_ready), 1);
    chk("reset.level",     int'(bus.level), 0);
    rst = 1'b0;

    //            iv  d      ordy  ov  od     ir  lvl
    vt[0]  = '{1, 8'hA5, 0, 1, 8'hA5, 1, 1};
    vt[1]  = '{0, 8'h00, 0, 1, 8'hA5, 1, 1};
    vt[2]  = '{0, 8'h00, 1, 0, 8'h00, 1, 0};
    vt[3]  = '{1, 8'h11, 0, 1, 8'h11, 1, 1};
    vt[4]  = '{1, 8'h22, 0, 1, 8'h11, 1, 2};
    vt[5]  = '{1, 8'h33, 0, 1, 8'h11, 1, 3};
    vt[6]  = '{1, 8'h44, 1, 1, 8'h22, 1, 3};
    vt[7]  = '{0, 8'h00, 1, 1, 8'h33, 1, 2};
    vt[8]  = '{0, 8'h00, 1, 1, 8'h44, 1, 1};
    vt[9]  = '{1, 8'h55, 1, 1, 8'h55, 1, 1};
    vt[10] = '{0, 8'h00, 1, 0, 8'h00, 1, 0};
    vt[11] = '{0, 8'h00, 1, 0, 8'h00, 1, 0};

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].iv, vt[i].d, vt[i].ordy);
      @(posedge clk); #1;
      chk($sformatf("vec%0d.out_valid", i), int'(bus.out_valid), int'(vt[i].e_ov));
      if (vt[i].e_ov) chk($sformatf("vec%0d.out_data", i), int'(bus.out_data), int'(vt[i].e_od));
      chk($sformatf("vec%0d.in_ready", i), int'(bus.in_ready), int'(vt[i].e_ir));
      chk($sformatf("vec%0d.level", i), int'(bus.level), vt[i].e_lvl);
    end

    // Fill to capacity with consumer stalled.
    for (int i = 0; i < 17; i++) mstep(1'b1, 8'(i), 1'b0, "fill");
    chk("fill.level17", int'(bus.level), 17);
    chk("fill.in_ready0", int'(bus.in_ready), 0);
    mstep(1'b1, 8'hFF, 1'b0, "fill18");
    chk("fill18.ignored", int'(bus.level), 17);

    // Drain: head must walk 0x00..0x10 one word per cycle.
    for (int k = 0; k < 17; k++) begin
      chk($sformatf("drain_order%0d", k), int'(bus.out_data), k);
      mstep(1'b0, 8'h00, 1'b1, "drainseq");
    end
    chk("drained.out_valid", int'(bus.out_valid), 0);
    chk("drained.in_ready", int'(bus.in_ready), 1);

    // Push+pop held at full: pop frees a slot, in_ready follows a cycle later.
    for (int i = 0; i < 17; i++) mstep(1'b1, 8'h40 + 8'(i), 1'b0, "refill");
    mstep(1'b1, 8'h80, 1'b1, "full_pp0");
    chk("full_pp.in_ready_late", int'(bus.in_ready), 1);
    for (int j = 1; j < 20; j++) mstep(1'b1, 8'h80 + 8'(j), 1'b1, "full_pp");
    drain_all();

    // Sustained push+pop at level 5.
    for (int i = 0; i < 5; i++) mstep(1'b1, 8'hC0 + 8'(i), 1'b0, "lvl5_fill");
    for (int j = 0; j < 10; j++) mstep(1'b1, 8'hD0 + 8'(j), 1'b1, "lvl5_pp");
    chk("lvl5.level", int'(bus.level), 5);
    drain_all();

    // Sustained push+pop at level 1 (head bypass).
    mstep(1'b1, 8'hE0, 1'b0, "lvl1_fill");
    for (int j = 1; j < 8; j++) mstep(1'b1, 8'hE0 + 8'(j), 1'b1, "lvl1_pp");
    chk("lvl1.level", int'(bus.level), 1);
    chk("lvl1.out_data", int'(bus.out_data), 8'hE7);
    drain_all();

    // Random independent valid/ready.
    for (int n = 0; n < 10000; n++)
      mstep(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)), "rand");
    drain_all();

    // Asynchronous reset mid-cycle at level 9.
    for (int i = 0; i < 9; i++) mstep(1'b1, 8'h90 + 8'(i), 1'b0, "pre_rst");
    chk("pre_rst.level9", int'(bus.level), 9);
    drive(1'b0, 8'h00, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst.out_valid", int'(bus.out_valid), 0);
    chk("arst.out_data",  int'(bus.out_data), 0);
    chk("arst.in_ready",  int'(bus.in_ready), 1);
    chk("arst.level",     int'(bus.level), 0);
    rst = 1'b0;
    mq.delete();
    mstep(1'b1, 8'h3C, 1'b0, "post_rst_push");
    chk("post_rst.head", int'(bus.out_data), 8'h3C);
    chk("post_rst.level", int'(bus.level), 1);
    mstep(1'b0, 8'h00, 1'b1, "post_rst_pop");
    chk("post_rst.alone", int'(bus.out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
